dice_reader: RTL and testbench

Consumer for the 8-bit pip-pattern bus driven by the dice block. Filters the bus for stability, decodes the LED pattern back to a face value 1–6, detects new rolls and flags illegal patterns. Also keeps a saturating per-player running score, where the player is selected by a one-hot turn vector. Sits between the dice output and the scoreboard/display logic, in the same clock domain as the dice block.

---
 rtl/dice_reader.sv | 241 ++++++++++++++++++++++++
 tb/tb_dice_reader.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dice_reader.sv
// -----------------------------------------------------------------------------
// dice_reader
//
// Consumes the 8-bit pip-pattern bus from the dice block. Each pattern must be
// stable before it is accepted. An accepted pattern is decoded to a face value
// of 1..6, to an idle/blank condition, or to an illegal pattern. Each accepted
// legal face is a roll, and a roll adds the face value to the score of the
// player selected by a one-hot turn vector. Scores saturate at the maximum.
//
// Parameters
//   STABLE_CYCLES  consecutive identical samples needed for acceptance (1..255)
//   SCORE_W        width of each player's score register (>= 3)
//
// Ports
//   clock     in   system clock, all state changes on posedge
//   reset     in   synchronous, active-low reset
//   display   in   [7:0] pip pattern from the dice block
//   turn      in   [3:0] one-hot current player
//   value     out  [2:0] accepted face 1..6, 0 when no face is accepted
//   valid     out  accepted pattern is a legal face
//   roll      out  one-cycle pulse after a new face is accepted
//   error     out  accepted pattern is illegal
//   bad_turn  out  sticky; a roll arrived while turn was not one-hot
//   score     out  [SCORE_W-1:0] score of the selected player, 0 if turn is
//                  not one-hot
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module dice_reader #(
  parameter int STABLE_CYCLES = 4,
  parameter int SCORE_W       = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [7:0]         display,
  input  logic [3:0]         turn,
  output logic [2:0]         value,
  output logic               valid,
  output logic               roll,
  output logic               error,
  output logic               bad_turn,
  output logic [SCORE_W-1:0] score
);

  localparam int                 NUM_PLAYERS = 4;
  localparam logic [7:0]         CNT_SAT     = 8'(STABLE_CYCLES);
  localparam logic [7:0]         CNT_ACCEPT  = 8'(STABLE_CYCLES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX   = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FACE,
    ST_FAULT
  } state_e;

  typedef enum logic [1:0] {
    PAT_IDLE,
    PAT_FACE,
    PAT_ILLEGAL
  } pat_class_e;

  typedef struct packed {
    pat_class_e cls;
    logic [2:0] face;
  } decode_t;

  // Maps a pip pattern to its class and, for legal faces, the face value.
  function automatic decode_t decode_pattern(input logic [7:0] pat);
    decode_t d;
    d.cls  = PAT_FACE;
    d.face = 3'd0;
    unique case (pat)
      8'b0000_0010: d.face = 3'd1;
      8'b1001_0000: d.face = 3'd2;
      8'b1001_0010: d.face = 3'd3;
      8'b0110_1100: d.face = 3'd4;
      8'b0111_1100: d.face = 3'd5;
      8'b1111_1100: d.face = 3'd6;
      8'b0000_0000,
      8'b0000_0001: d.cls  = PAT_IDLE;
      default:      d.cls  = PAT_ILLEGAL;
    endcase
    return d;
  endfunction

  // Adds a face to a score and clamps at the all-ones maximum.
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [2:0]         f);
    logic [SCORE_W:0] f_ext;
    logic [SCORE_W:0] sum;
    f_ext      = '0;
    f_ext[2:0] = f;
    sum        = {1'b0, a} + f_ext;
    return sum[SCORE_W] ? SCORE_MAX : sum[SCORE_W-1:0];
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [7:0]         samp_q,     samp_d;
  logic [7:0]         cnt_q,      cnt_d;
  logic [7:0]         acc_q,      acc_d;
  state_e             state_q,    state_d;
  logic [2:0]         value_q,    value_d;
  logic               roll_q,     roll_d;
  logic               bad_turn_q, bad_turn_d;
  logic [SCORE_W-1:0] score_q [NUM_PLAYERS];
  logic [SCORE_W-1:0] score_d [NUM_PLAYERS];

  // ---------------------------------------------------------------------------
  // Input filter
  // ---------------------------------------------------------------------------
  logic    stable;
  logic    accept;
  decode_t dec;

  assign stable = (display == samp_q);
  // The count reaching its threshold only accepts while the bus still matches
  // the previous sample, so a change on that very edge restarts the count.
  // Comparing against acc_q stops an unchanged pattern from rolling twice.
  assign accept = stable && (cnt_q == CNT_ACCEPT) && (display != acc_q);
  assign dec    = decode_pattern(display);

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    samp_d = display;
    cnt_d  = cnt_q;
    if (!stable) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_SAT) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Turn decode
  // ---------------------------------------------------------------------------
  logic       turn_onehot;
  logic [1:0] turn_idx;

  assign turn_onehot = (turn != 4'd0) && ((turn & (turn - 4'd1)) == 4'd0);

  always_comb begin
    turn_idx = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (turn[i]) turn_idx = 2'(i);
    end
  end

  // ---------------------------------------------------------------------------
  // Accepted-pattern FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    value_d = value_q;
    roll_d  = 1'b0;
    if (accept) begin
      acc_d = display;
      unique case (dec.cls)
        PAT_IDLE: begin
          state_d = ST_IDLE;
          value_d = 3'd0;
        end
        PAT_FACE: begin
          state_d = ST_FACE;
          value_d = dec.face;
          roll_d  = 1'b1;
        end
        default: begin
          state_d = ST_FAULT;
          value_d = 3'd0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Scoring: a roll credits the player selected by the turn vector sampled on
  // the accepting edge, or flags the turn if it is not one-hot.
  // ---------------------------------------------------------------------------
  always_comb begin
    score_d    = score_q;
    bad_turn_d = bad_turn_q;
    if (accept && (dec.cls == PAT_FACE)) begin
      if (turn_onehot) begin
        score_d[turn_idx] = sat_add(score_q[turn_idx], dec.face);
      end else begin
        bad_turn_d = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    // NOTE: state updates use non-blocking assignments, so every flop samples
    // the values that held before the edge, whatever order the lines are in.
    if (!reset) begin
      samp_q     <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      state_q    <= ST_IDLE;
      value_q    <= '0;
      roll_q     <= 1'b0;
      bad_turn_q <= 1'b0;
      // NOTE: the score array is architectural state that must read 0 after
      // reset, so it is cleared here like any other flop. It is not left as an
      // unreset memory.
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        score_q[i] <= '0;
      end
    end else begin
      samp_q     <= samp_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      state_q    <= state_d;
      value_q    <= value_d;
      roll_q     <= roll_d;
      bad_turn_q <= bad_turn_d;
      score_q    <= score_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign value    = value_q;
  assign roll     = roll_q;
  assign bad_turn = bad_turn_q;
  assign valid    = (state_q == ST_FACE);
  assign error    = (state_q == ST_FAULT);

  always_comb begin
    score = '0;
    if (turn_onehot) score = score_q[turn_idx];
  end

endmodule

// File: tb/tb_dice_reader.sv
// -----------------------------------------------------------------------------
// tb_dice_reader
//
// Two instances of dice_reader (STABLE_CYCLES = 4 and 1) see the same inputs.
// A behavioural model tracks how long the bus has held the same value on
// consecutive edges and the per-player scores. A compare process checks every
// output of both instances on each falling edge. Directed literal checks pin
// the model and the key scenarios. A randomized phase follows them.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_dice_reader;

  localparam int SCORE_W   = 8;
  localparam int SCORE_MAX = (1 << SCORE_W) - 1;
  localparam logic [7:0] FACE_PAT [6] = '{8'b00000010, 8'b10010000,
                                          8'b10010010, 8'b01101100,
                                          8'b01111100, 8'b11111100};

  logic               clock = 1'b0;
  logic               reset;
  logic [7:0]         display;
  logic [3:0]         turn;

  logic [2:0]         d0_value,    d1_value;
  logic               d0_valid,    d1_valid;
  logic               d0_roll,     d1_roll;
  logic               d0_error,    d1_error;
  logic               d0_bad_turn, d1_bad_turn;
  logic [SCORE_W-1:0] d0_score,    d1_score;

  always #5 clock = ~clock;

  dice_reader #(.STABLE_CYCLES(4), .SCORE_W(SCORE_W)) dut0 (
    .clock(clock), .reset(reset), .display(display), .turn(turn),
    .value(d0_value), .valid(d0_valid), .roll(d0_roll), .error(d0_error),
    .bad_turn(d0_bad_turn), .score(d0_score)
  );

  dice_reader #(.STABLE_CYCLES(1), .SCORE_W(SCORE_W)) dut1 (
    .clock(clock), .reset(reset), .display(display), .turn(turn),
    .value(d1_value), .valid(d1_valid), .roll(d1_roll), .error(d1_error),
    .bad_turn(d1_bad_turn), .score(d1_score)
  );

  int n_vec  = 0;
  int n_miss = 0;
  int rolls0 = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  int         m_stable [2] = '{4, 1};
  int         m_run    [2];
  logic [7:0] m_prev   [2];
  logic [7:0] m_acc    [2];
  int         m_value  [2];
  int         m_valid  [2];
  int         m_error  [2];
  int         m_roll   [2];
  int         m_bad    [2];
  int         m_score  [2][4];
  bit         m_ready = 1'b0;

  function automatic int face_of(input logic [7:0] p);
    for (int i = 0; i < 6; i++) begin
      if (p == FACE_PAT[i]) return i + 1;
    end
    return 0;
  endfunction

  function automatic int exp_score(input int m);
    int r = 0;
    if ($countones(turn) == 1) begin
      for (int i = 0; i < 4; i++) if (turn[i]) r = m_score[m][i];
    end
    return r;
  endfunction

  task automatic model_step(input int m);
    int f;
    if (!reset) begin
      // The reset edge behaves as if an all-zero pattern had been sampled.
      m_prev[m] = 8'h00;
      m_run[m]  = 1;
      m_acc[m]  = 8'h00;
      m_value[m] = 0; m_valid[m] = 0; m_error[m] = 0; m_roll[m] = 0; m_bad[m] = 0;
      for (int i = 0; i < 4; i++) m_score[m][i] = 0;
    end else begin
      if (display == m_prev[m]) begin
        if (m_run[m] < 1000) m_run[m]++;
      end else begin
        m_run[m] = 1;
      end
      m_prev[m] = display;
      m_roll[m] = 0;
      // Accepted once the same pattern has been seen on STABLE_CYCLES+1 edges.
      if (m_run[m] == m_stable[m] + 1 && display != m_acc[m]) begin
        m_acc[m] = display;
        f = face_of(display);
        if (f != 0) begin
          m_value[m] = f; m_valid[m] = 1; m_error[m] = 0; m_roll[m] = 1;
          if ($countones(turn) == 1) begin
            for (int i = 0; i < 4; i++) begin
              if (turn[i]) m_score[m][i] = (m_score[m][i] + f > SCORE_MAX) ?
                                           SCORE_MAX : m_score[m][i] + f;
            end
          end else begin
            m_bad[m] = 1;
          end
        end else if (display == 8'h00 || display == 8'h01) begin
          m_value[m] = 0; m_valid[m] = 0; m_error[m] = 0;
        end else begin
          m_value[m] = 0; m_valid[m] = 0; m_error[m] = 1;
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clock);
      model_step(0);
      model_step(1);
      if (!reset) m_ready = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-cycle compare, away from the active edge
  // ---------------------------------------------------------------------------
  initial begin
    forever begin
      @(negedge clock);
      if (d0_roll === 1'b1) rolls0++;
      if (m_ready) begin
        check("d0 value",    int'(d0_value),    m_value[0]);
        check("d0 valid",    int'(d0_valid),    m_valid[0]);
        check("d0 roll",     int'(d0_roll),     m_roll[0]);
        check("d0 error",    int'(d0_error),    m_error[0]);
        check("d0 bad_turn", int'(d0_bad_turn), m_bad[0]);
        check("d0 score",    int'(d0_score),    exp_score(0));
        check("d1 value",    int'(d1_value),    m_value[1]);
        check("d1 valid",    int'(d1_valid),    m_valid[1]);
        check("d1 roll",     int'(d1_roll),     m_roll[1]);
        check("d1 error",    int'(d1_error),    m_error[1]);
        check("d1 bad_turn", int'(d1_bad_turn), m_bad[1]);
        check("d1 score",    int'(d1_score),    exp_score(1));
      end
    end
  end

  // Inputs change 2 time units after a rising edge and hold for n edges.
  task automatic hold(input logic [7:0] p, input logic [3:0] t, input int n);
    display = p;
    turn    = t;
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Stimulus with directed literal expectations, then randomized traffic
  // ---------------------------------------------------------------------------
  initial begin
    int r0;
    int sel;
    logic [7:0] pat;
    logic [7:0] last_pat;
    reset = 1'b0; display = 8'h00; turn = 4'b0000;
    repeat (2) @(posedge clock);
    #2;
    check("reset value", int'(d0_value), 0);
    check("reset valid", int'(d0_valid), 0);
    check("reset score", int'(d0_score), 0);
    reset = 1'b1;

    // A face of 4 held for 6 cycles is accepted on the 5th edge.
    r0 = rolls0;
    hold(8'b01101100, 4'b0001, 4);
    check("t1 not yet", int'(d0_valid), 0);
    hold(8'b01101100, 4'b0001, 2);
    check("t1 value", int'(d0_value), 4);
    check("t1 valid", int'(d0_valid), 1);
    check("t1 rolls", rolls0 - r0, 1);
    check("t1 score", int'(d0_score), 4);

    // Short glitch, and a change on the threshold edge: neither is accepted.
    r0 = rolls0;
    hold(8'b10010010, 4'b0001, 2);
    hold(8'b01101100, 4'b0001, 6);
    hold(8'b10010000, 4'b0001, 4);
    hold(8'b01101100, 4'b0001, 6);
    check("t2 value", int'(d0_value), 4);
    check("t2 rolls", rolls0 - r0, 0);
    check("t2 score", int'(d0_score), 4);

    // Player 1: 1, idle, 1 gives two rolls; then 6, glitch, 6 gives one roll.
    r0 = rolls0;
    hold(8'b00000010, 4'b0010, 6);
    hold(8'b00000001, 4'b0010, 6);
    hold(8'b00000010, 4'b0010, 6);
    check("t3 rolls", rolls0 - r0, 2);
    check("t3 score", int'(d0_score), 2);
    r0 = rolls0;
    hold(8'b11111100, 4'b0010, 6);
    hold(8'b10010000, 4'b0010, 2);
    hold(8'b11111100, 4'b0010, 6);
    check("t3 six rolls", rolls0 - r0, 1);
    check("t3 six score", int'(d0_score), 8);

    // Illegal pattern gives a fault, then a legal 2 clears it.
    r0 = rolls0;
    hold(8'b11111111, 4'b0010, 6);
    check("t4 error", int'(d0_error), 1);
    check("t4 valid", int'(d0_valid), 0);
    check("t4 value", int'(d0_value), 0);
    check("t4 rolls", rolls0 - r0, 0);
    hold(8'b10010000, 4'b0010, 6);
    check("t4 error clr", int'(d0_error), 0);
    check("t4 value2", int'(d0_value), 2);
    check("t4 rolls2", rolls0 - r0, 1);

    // Non-one-hot turn during a roll.
    hold(8'b01111100, 4'b0110, 6);
    check("t5 bad_turn", int'(d0_bad_turn), 1);
    check("t5 score out", int'(d0_score), 0);
    hold(8'b01111100, 4'b0001, 1);
    check("t5 p0 score", int'(d0_score), 4);
    hold(8'b01111100, 4'b0010, 1);
    check("t5 p1 score", int'(d0_score), 10);
    hold(8'b00000001, 4'b0001, 6);
    check("t5 sticky", int'(d0_bad_turn), 1);

    // Saturation of player 0.
    reset = 1'b0;
    hold(8'b00000001, 4'b0001, 1);
    reset = 1'b1;
    check("t6 bad clr", int'(d0_bad_turn), 0);
    r0 = rolls0;
    for (int i = 0; i < 42; i++) begin
      hold(8'b11111100, 4'b0001, 6);
      hold(8'b00000001, 4'b0001, 6);
    end
    check("t6 score 42", int'(d0_score), 252);
    hold(8'b11111100, 4'b0001, 6);
    check("t6 score sat", int'(d0_score), 255);
    check("t6 rolls", rolls0 - r0, 43);
    hold(8'b00000001, 4'b0001, 6);
    hold(8'b11111100, 4'b0001, 6);
    check("t6 stays sat", int'(d0_score), 255);

    // Reset in the middle of stabilisation discards the partial count.
    hold(8'b01101100, 4'b0001, 6);
    hold(8'b10010010, 4'b0001, 2);
    reset = 1'b0;
    hold(8'b10010010, 4'b0001, 1);
    reset = 1'b1;
    check("t7 value", int'(d0_value), 0);
    check("t7 valid", int'(d0_valid), 0);
    check("t7 roll", int'(d0_roll), 0);
    check("t7 error", int'(d0_error), 0);
    check("t7 score", int'(d0_score), 0);
    hold(8'b10010010, 4'b0001, 4);
    check("t7 not yet", int'(d0_value), 0);
    hold(8'b10010010, 4'b0001, 1);
    check("t7 accepted", int'(d0_value), 3);

    // STABLE_CYCLES = 1: two matching samples are enough.
    hold(8'b01101100, 4'b0001, 2);
    check("t8 d1 value", int'(d1_value), 4);
    check("t8 d0 value", int'(d0_value), 3);

    // Randomized traffic.
    last_pat = 8'h00;
    for (int it = 0; it < 1500; it++) begin
      sel = $urandom_range(0, 9);
      if (sel < 6)       pat = FACE_PAT[sel];
      else if (sel == 6) pat = 8'h00;
      else if (sel == 7) pat = 8'h01;
      else if (sel == 8) pat = 8'($urandom_range(0, 255));
      else               pat = last_pat;
      last_pat = pat;
      if ($urandom_range(0, 3) != 0) turn = 4'(1 << $urandom_range(0, 3));
      else                           turn = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 59) == 0) reset = 1'b0;
      hold(pat, turn, $urandom_range(1, 8));
      reset = 1'b1;
    end
    hold(8'h01, 4'b0001, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
